dcache_assoc: RTL

//  Parametrised N-way set-associative, write-back, write-allocate data cache between the

---
 rtl/dcache_assoc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with age-based LRU.
// One miss is serviced at a time; p1_stall_o freezes the pipeline until the request completes.
module dcache_assoc #(
  parameter int WAYS   = 2,
  parameter int SETS   = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = OFF_W - 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_e;
  typedef logic [WAY_W-1:0] way_t;

  state_e state_q, state_d;
  way_t   victim_q, victim_d;

  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  way_t              age_q   [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] line_q  [WAYS][SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic              req;
  logic              unused_byte_off;

  assign idx             = p1_addr_i[OFF_W +: IDX_W];
  assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel            = p1_addr_i[OFF_W-1:2];
  assign req             = p1_MemRead_i | p1_MemWrite_i;
  assign unused_byte_off = ^p1_addr_i[1:0];

  logic              hit;
  way_t              hit_way;
  way_t              hit_age;
  logic [DATA_W-1:0] hit_word;
  logic              hit_idle;

  // NOTE: every signal driven in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
  end

  always_comb begin
    hit_age  = age_q[hit_way][idx];
    hit_word = line_q[hit_way][idx][wsel*DATA_W +: DATA_W];
    hit_idle = (state_q == S_IDLE) && req && hit;
    p1_data_o = ((state_q == S_IDLE) && hit) ? hit_word : '0;
  end

  // Victim: lowest-index invalid way, otherwise the oldest way (age == WAYS-1).
  logic have_free;
  way_t victim;

  always_comb begin
    have_free = 1'b0;
    victim    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        have_free = 1'b1;
        victim    = way_t'(w);
      end
    end
    if (!have_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][idx] == way_t'(WAYS - 1)) victim = way_t'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          p1_stall_o = 1'b1;
          victim_d   = victim;
          state_d    = (valid_q[victim][idx] && dirty_q[victim][idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
        mem_data_o   = line_q[victim_q][idx];
        if (mem_ack_i) state_d = S_IDLE;
      end
      S_ALLOCATE: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, victim pointer and per-line valid/dirty/age.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= way_t'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_idle) begin
        if (p1_MemWrite_i) dirty_q[hit_way][idx] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (way_t'(w) == hit_way)         age_q[w][idx] <= '0;
          else if (age_q[w][idx] < hit_age) age_q[w][idx] <= age_q[w][idx] + way_t'(1);
        end
      end
      if ((state_q == S_WRITEBACK) && mem_ack_i) dirty_q[victim_q][idx] <= 1'b0;
      if ((state_q == S_ALLOCATE) && mem_ack_i) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are storage, not control; they are never reset because valid gates them.
  always_ff @(posedge clk_i) begin
    if (hit_idle && p1_MemWrite_i) line_q[hit_way][idx][wsel*DATA_W +: DATA_W] <= p1_data_i;
    if ((state_q == S_ALLOCATE) && mem_ack_i) begin
      line_q[victim_q][idx] <= mem_data_i;
      tag_q[victim_q][idx]  <= req_tag;
    end
  end

endmodule
